// File: rtl/scan_test_ctrl_if.sv
// Host-side bundle for scan_test_ctrl: test request, pattern, status and results.
// The master drives a test request; the slave (the controller) returns the results.
interface scan_test_ctrl_if #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned IDX_W     = 4
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] resp;
  logic [IDX_W-1:0]     mismatch_cnt;
  logic [IDX_W-1:0]     first_fail;
  logic [IDX_W-1:0]     last_fail;

  modport master (
    output start, pattern,
    input  busy, done, pass, resp, mismatch_cnt, first_fail, last_fail
  );

  modport slave (
    input  start, pattern,
    output busy, done, pass, resp, mismatch_cnt, first_fail, last_fail
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan test controller: shifts a pattern into a serial chain, unloads it, and reports
// mismatch count plus lowest/highest failing bit positions.
module scan_test_ctrl #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  scan_test_ctrl_if.slave  io_ctrl,
  output logic             o_test_mode,
  output logic             o_scan_in,
  input  logic             i_scan_out
);

  localparam int unsigned CntW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StUnload, StDone} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [CntW-1:0]      r_cnt;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_resp;
  logic [IDX_W-1:0]     r_mcnt;
  logic [IDX_W-1:0]     r_first;
  logic [IDX_W-1:0]     r_last;
  logic                 r_pass;
  logic                 r_test_mode;
  logic                 r_scan_in;

  logic                 w_accept;
  logic                 w_cnt_last;
  logic                 w_mismatch;
  logic [CntW-1:0]      w_cnt_inc;

  always_comb begin
    w_accept     = (r_state == StIdle) && io_ctrl.start;
    w_cnt_last   = (r_cnt == CntLast);
    w_cnt_inc    = r_cnt + CntW'(1);
    w_mismatch   = i_scan_out ^ r_pat[r_cnt];
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (io_ctrl.start) w_state_next = StLoad;
      StLoad:   if (w_cnt_last) w_state_next = StUnload;
      StUnload: if (w_cnt_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_pat       <= '0;
      r_resp      <= '0;
      r_mcnt      <= '0;
      r_first     <= '0;
      r_last      <= '0;
      r_pass      <= 1'b0;
      r_test_mode <= 1'b0;
      r_scan_in   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pat       <= io_ctrl.pattern;
        r_cnt       <= '0;
        r_test_mode <= 1'b1;
        r_scan_in   <= io_ctrl.pattern[0];
        r_resp      <= '0;
        r_mcnt      <= '0;
        r_first     <= '0;
        r_last      <= '0;
        r_pass      <= 1'b0;
      end else if (r_state == StLoad) begin
        // Counter wraps to 0 on the last load shift so unload indexes from bit 0.
        r_cnt     <= w_cnt_last ? '0 : w_cnt_inc;
        r_scan_in <= w_cnt_last ? 1'b0 : r_pat[w_cnt_inc];
      end else if (r_state == StUnload) begin
        r_cnt         <= w_cnt_last ? '0 : w_cnt_inc;
        r_resp[r_cnt] <= i_scan_out;
        if (w_mismatch) begin
          r_mcnt <= r_mcnt + IDX_W'(1);
          r_last <= IDX_W'(r_cnt);
          if (r_mcnt == '0) r_first <= IDX_W'(r_cnt);
        end
        if (w_cnt_last) begin
          r_test_mode <= 1'b0;
          r_pass      <= (r_mcnt == '0) && !w_mismatch;
        end
      end
    end
  end

  assign o_test_mode          = r_test_mode;
  assign o_scan_in            = r_scan_in;
  assign io_ctrl.busy         = (r_state != StIdle);
  assign io_ctrl.done         = (r_state == StDone);
  assign io_ctrl.pass         = r_pass;
  assign io_ctrl.resp         = r_resp;
  assign io_ctrl.mismatch_cnt = r_mcnt;
  assign io_ctrl.first_fail   = r_first;
  assign io_ctrl.last_fail    = r_last;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl: behavioural scan chain with an injectable stuck-at fault
// and a reference model of the expected response signature.
module tb_scan_test_ctrl;
  localparam int N  = 8;
  localparam int IW = 4;

  logic clk;
  logic reset_n;
  logic test_mode;
  logic scan_in;
  logic scan_out;

  int total = 0;
  int bad   = 0;

  scan_test_ctrl_if #(.CHAIN_LEN(N), .IDX_W(IW)) bus ();

  scan_test_ctrl #(.CHAIN_LEN(N), .IDX_W(IW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .io_ctrl     (bus),
    .o_test_mode (test_mode),
    .o_scan_in   (scan_in),
    .i_scan_out  (scan_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain: scan_in enters the MSB, bit 0 drives scan_out. The fault corrupts the
  // bits that pass through the faulty flop while loading.
  logic [N-1:0] chain = '0;
  int           shift_n = 0;
  bit           fault_en = 1'b0;
  int           fault_pos = 0;
  logic         fault_val = 1'b0;
  assign scan_out = chain[0];

  always @(posedge clk) begin
    logic [N-1:0] nxt;
    if (test_mode) begin
      nxt = {scan_in, chain[N-1:1]};
      if (fault_en && shift_n < N) nxt[fault_pos] = fault_val;
      chain   <= nxt;
      shift_n <= shift_n + 1;
    end else begin
      shift_n <= 0;
    end
  end

  // Signature: bits at or below a stuck position read the stuck value.
  function automatic void model(input logic [N-1:0] pat, input bit fen, input int fpos,
                                input logic fv, output logic [N-1:0] r, output int cnt,
                                output int ff, output int lf);
    r = pat;
    if (fen) for (int k = 0; k <= fpos; k++) r[k] = fv;
    cnt = 0; ff = 0; lf = 0;
    for (int k = 0; k < N; k++) begin
      if (r[k] != pat[k]) begin
        if (cnt == 0) ff = k;
        lf = k;
        cnt++;
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one edge (E0), then scramble pattern to prove it was captured.
  task automatic accept(input logic [N-1:0] pat);
    bus.start   = 1'b1;
    bus.pattern = pat;
    step();
    bus.start   = 1'b0;
    bus.pattern = ~pat;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      step();
      lat++;
    end
    if (!bus.done) lat = -1;
  endtask

  task automatic set_fault(input bit en, input int pos, input logic v);
    fault_en  = en;
    fault_pos = pos;
    fault_val = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.pattern = '0;
    step();
    step();
    total++;
    if ({bus.busy, test_mode, scan_in, bus.done, bus.pass, bus.resp, bus.mismatch_cnt,
         bus.first_fail, bus.last_fail} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b tm=%b si=%b done=%b pass=%b resp=%h want all 0",
               bus.busy, test_mode, scan_in, bus.done, bus.pass, bus.resp);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_fault_free();
    int lat;
    set_fault(0, 0, 1'b0);
    accept(8'hA5);
    total++;
    if ({bus.busy, test_mode, scan_in} !== 3'b111) begin
      bad++;
      $display("FAIL accept_outputs: busy/tm/si=%b want 111", {bus.busy, test_mode, scan_in});
    end
    wait_done(lat);
    total++;
    if (lat != 2 * N) begin
      bad++;
      $display("FAIL done_latency: got %0d want %0d", lat, 2 * N);
    end
    total++;
    if (test_mode !== 1'b0) begin
      bad++;
      $display("FAIL done_test_mode: got %b want 0", test_mode);
    end
    total++;
    if ({bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail} !==
        {8'hA5, 1'b1, 4'd0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL a5_results: resp=%h pass=%b cnt=%0d ff=%0d lf=%0d want a5 1 0 0 0",
               bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail);
    end
    step();
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL after_done: busy/done=%b want 00", {bus.busy, bus.done});
    end
    total++;
    if (bus.resp !== 8'hA5 || bus.pass !== 1'b1) begin
      bad++;
      $display("FAIL result_hold: resp=%h pass=%b want a5 1", bus.resp, bus.pass);
    end
  endtask

  task automatic test_stuck0();
    int lat;
    set_fault(1, 3, 1'b0);
    accept(8'hFF);
    wait_done(lat);
    total++;
    if ({bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail} !==
        {8'hF0, 1'b0, 4'd4, 4'd0, 4'd3}) begin
      bad++;
      $display("FAIL sa0_pos3: resp=%h pass=%b cnt=%0d ff=%0d lf=%0d want f0 0 4 0 3",
               bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail);
    end
    step();
  endtask

  task automatic test_stuck1();
    int lat;
    set_fault(1, 5, 1'b1);
    accept(8'h00);
    wait_done(lat);
    total++;
    if ({bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail} !==
        {8'h3F, 1'b0, 4'd6, 4'd0, 4'd5}) begin
      bad++;
      $display("FAIL sa1_pos5: resp=%h pass=%b cnt=%0d ff=%0d lf=%0d want 3f 0 6 0 5",
               bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail, bus.last_fail);
    end
    step();
    accept(8'hFF);
    total++;
    if (bus.pass !== 1'b0 || bus.mismatch_cnt !== 4'd0) begin
      bad++;
      $display("FAIL clear_on_load: pass=%b cnt=%0d want 0 0", bus.pass, bus.mismatch_cnt);
    end
    wait_done(lat);
    total++;
    if (bus.pass !== 1'b1 || bus.resp !== 8'hFF) begin
      bad++;
      $display("FAIL sa1_masked: pass=%b resp=%h want 1 ff", bus.pass, bus.resp);
    end
    step();
    set_fault(0, 0, 1'b0);
  endtask

  task automatic test_ignored_start();
    int dones = 0;
    accept(8'h96);
    for (int i = 0; i < 40; i++) begin
      if (i == 3 || i == N + 3) begin
        bus.start   = 1'b1;
        bus.pattern = 8'h3C;
      end else begin
        bus.start = 1'b0;
      end
      step();
      if (bus.done) begin
        dones++;
        total++;
        if (bus.resp !== 8'h96 || bus.pass !== 1'b1) begin
          bad++;
          $display("FAIL ignored_start_pat: resp=%h pass=%b want 96 1", bus.resp, bus.pass);
        end
      end
    end
    total++;
    if (dones != 1) begin
      bad++;
      $display("FAIL ignored_start_dones: got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_midtest();
    int dones = 0;
    int lat;
    accept(8'hC3);
    for (int i = 0; i < N + 4; i++) step();
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.busy, test_mode, scan_in, bus.done, bus.pass, bus.resp, bus.mismatch_cnt,
         bus.first_fail, bus.last_fail} !== '0) begin
      bad++;
      $display("FAIL midtest_reset: busy=%b tm=%b resp=%h cnt=%0d want all 0",
               bus.busy, test_mode, bus.resp, bus.mismatch_cnt);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 2 * N + 4; i++) begin
      step();
      if (bus.done || bus.busy) dones++;
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL midtest_no_done: busy/done seen %0d cycles want 0", dones);
    end
    accept(8'h5A);
    wait_done(lat);
    total++;
    if (lat != 2 * N || bus.resp !== 8'h5A || bus.pass !== 1'b1) begin
      bad++;
      $display("FAIL after_reset_test: lat=%0d resp=%h pass=%b want %0d 5a 1",
               lat, bus.resp, bus.pass, 2 * N);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int q[$];
    int lat;
    logic [N-1:0] pat = N'($urandom);
    bus.start   = 1'b1;
    bus.pattern = pat;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.done) begin
        q.push_back(i);
        total++;
        if (bus.resp !== pat || bus.pass !== 1'b1) begin
          bad++;
          $display("FAIL b2b_result: resp=%h pass=%b want %h 1", bus.resp, bus.pass, pat);
        end
      end
    end
    bus.start = 1'b0;
    total++;
    if (q.size() != 2 || q[0] != 2 * N || q[1] != 4 * N + 2) begin
      bad++;
      $display("FAIL b2b_timing: %0d dones, first at %0d want 2 at %0d and %0d",
               q.size(), (q.size() > 0) ? q[0] : -1, 2 * N, 4 * N + 2);
    end
    wait_done(lat);
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pat, er;
    int cnt, ff, lf, lat, mode, pos;
    for (int t = 0; t < 20; t++) begin
      pat  = N'($urandom);
      mode = int'($urandom_range(0, 2));
      pos  = int'($urandom_range(0, N - 1));
      set_fault(mode != 0, pos, mode == 2);
      model(pat, mode != 0, pos, mode == 2, er, cnt, ff, lf);
      accept(pat);
      wait_done(lat);
      total++;
      if (lat != 2 * N || bus.resp !== er || bus.pass !== (cnt == 0) ||
          bus.mismatch_cnt !== IW'(cnt) || bus.first_fail !== IW'(ff) ||
          bus.last_fail !== IW'(lf)) begin
        bad++;
        $display("FAIL random_%0d: pat=%h lat=%0d resp=%h pass=%b cnt=%0d ff=%0d lf=%0d want %0d %h %b %0d %0d %0d",
                 t, pat, lat, bus.resp, bus.pass, bus.mismatch_cnt, bus.first_fail,
                 bus.last_fail, 2 * N, er, cnt == 0, cnt, ff, lf);
      end
      step();
    end
    set_fault(0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck0();
    test_stuck1();
    test_ignored_start();
    test_reset_midtest();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
